// File: rtl/if_id_pipe_reg_if.sv
// IF/ID pipeline register bus: fetch/control inputs and decode-facing outputs.
// The master drives the fetch side; the slave is the pipeline register.
interface if_id_pipe_reg_if;
  logic        freeze;
  logic        flush;
  logic [15:0] i_pc_plus4;
  logic [31:0] i_ir;
  logic [15:0] o_pc_plus4;
  logic [31:0] o_ir;
  logic        o_valid;
  logic        o_held;
  logic [15:0] o_stall_cnt;
  logic [15:0] o_flush_cnt;

  modport master (
    output freeze, flush, i_pc_plus4, i_ir,
    input  o_pc_plus4, o_ir, o_valid, o_held,
    input  o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  freeze, flush, i_pc_plus4, i_ir,
    output o_pc_plus4, o_ir, o_valid, o_held,
    output o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with stall hold and flush bubble insertion.
// Define IF_ID_PERF_CNT_EN to build saturating stall/flush counters.
module if_id_pipe_reg (
  input logic           clk,
  input logic           rst,
  if_id_pipe_reg_if.slave bus
);

  // State bits map directly onto {o_valid, o_held}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    HELD  = 2'b11
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] ir_q;
  logic [15:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else if (bus.freeze) begin
      if (state_q == EMPTY) begin
        state_d = EMPTY;
      end else begin
        state_d = HELD;
      end
    end else begin
      state_d = FULL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= '0;
      pc_q <= '0;
    end else if (bus.flush) begin
      ir_q <= '0;
      pc_q <= '0;
    end else if (!bus.freeze) begin
      ir_q <= bus.i_ir;
      pc_q <= bus.i_pc_plus4;
    end
  end

  assign bus.o_ir       = ir_q;
  assign bus.o_pc_plus4 = pc_q;
  assign bus.o_valid    = state_q[1];
  assign bus.o_held     = state_q[0];

`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Flush dominates: a frozen+flushed edge counts only as a flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.flush && flush_cnt_q != 16'hFFFF) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
      if (bus.freeze && !bus.flush &&
          stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign bus.o_stall_cnt = stall_cnt_q;
  assign bus.o_flush_cnt = flush_cnt_q;
`else
  assign bus.o_stall_cnt = 16'h0;
  assign bus.o_flush_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed self-checking bench for if_id_pipe_reg.
// Counter expectations follow IF_ID_PERF_CNT_EN.
module tb_if_id_pipe_reg;

`ifdef IF_ID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  if_id_pipe_reg_if bus ();

  if_id_pipe_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt(
    input int n
  );
    return PERF ? 32'(n) : 32'h0;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_valid), 0);
    chk({tag, "_held"}, 32'(bus.o_held), 0);
    chk({tag, "_ir"}, bus.o_ir, 0);
    chk({tag, "_pc"}, 32'(bus.o_pc_plus4), 0);
    chk({tag, "_scnt"}, 32'(bus.o_stall_cnt), 0);
    chk({tag, "_fcnt"}, 32'(bus.o_flush_cnt), 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.freeze = 1'b0;
    bus.flush = 1'b0;
    bus.i_ir = 32'h0;
    bus.i_pc_plus4 = 16'h0;

    // async reset before any clock edge
    #3 rst = 1'b1;
    #1 chk_zero("rst");
    step();
    rst = 1'b0;
    bus.i_ir = 32'hA5A5_0001;
    bus.i_pc_plus4 = 16'h0004;
    step();
    chk("load_valid", 32'(bus.o_valid), 1);
    chk("load_ir", bus.o_ir, 32'hA5A5_0001);
    chk("load_pc", 32'(bus.o_pc_plus4), 32'h0004);
    chk("load_held", 32'(bus.o_held), 0);

    // stall
    bus.i_ir = 32'h1111_1111;
    bus.i_pc_plus4 = 16'h0008;
    step();
    chk("st0_ir", bus.o_ir, 32'h1111_1111);
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_ir = 32'h2222_0000 + 32'(i);
      bus.i_pc_plus4 = 16'h0100 + 16'(i);
      step();
      chk("st_ir", bus.o_ir, 32'h1111_1111);
      chk("st_pc", 32'(bus.o_pc_plus4), 32'h0008);
      chk("st_held", 32'(bus.o_held), 1);
      chk("st_valid", 32'(bus.o_valid), 1);
    end
    chk("st_cnt", 32'(bus.o_stall_cnt), cnt(3));
    bus.freeze = 1'b0;
    bus.i_ir = 32'h3333_3333;
    bus.i_pc_plus4 = 16'h000C;
    step();
    chk("rel_ir", bus.o_ir, 32'h3333_3333);
    chk("rel_pc", 32'(bus.o_pc_plus4), 32'h000C);
    chk("rel_held", 32'(bus.o_held), 0);

    // flush from FULL
    bus.flush = 1'b1;
    bus.i_ir = 32'hDEAD_BEEF;
    step();
    bus.flush = 1'b0;
    chk("fl_valid", 32'(bus.o_valid), 0);
    chk("fl_ir", bus.o_ir, 0);
    chk("fl_pc", 32'(bus.o_pc_plus4), 0);
    chk("fl_fcnt", 32'(bus.o_flush_cnt), cnt(1));

    // freeze in EMPTY stays EMPTY
    bus.freeze = 1'b1;
    step();
    chk("emf_valid", 32'(bus.o_valid), 0);
    chk("emf_held", 32'(bus.o_held), 0);
    chk("emf_scnt", 32'(bus.o_stall_cnt), cnt(4));

    // freeze + flush in HELD
    bus.freeze = 1'b0;
    bus.i_ir = 32'h4444_4444;
    bus.i_pc_plus4 = 16'h0010;
    step();
    bus.freeze = 1'b1;
    step();
    chk("sim_pre_held", 32'(bus.o_held), 1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.freeze = 1'b0;
    chk("sim_valid", 32'(bus.o_valid), 0);
    chk("sim_held", 32'(bus.o_held), 0);
    chk("sim_ir", bus.o_ir, 0);
    chk("sim_scnt", 32'(bus.o_stall_cnt), cnt(5));
    chk("sim_fcnt", 32'(bus.o_flush_cnt), cnt(2));

    // reset mid-stall
    bus.i_ir = 32'h5555_5555;
    bus.i_pc_plus4 = 16'h0014;
    step();
    bus.freeze = 1'b1;
    step();
    chk("ms_held", 32'(bus.o_held), 1);
    #2 rst = 1'b1;
    #1 chk_zero("ms");
    bus.freeze = 1'b0;
    step();
    rst = 1'b0;
    bus.i_ir = 32'h6666_6666;
    bus.i_pc_plus4 = 16'h0018;
    step();
    chk("ms_rel_valid", 32'(bus.o_valid), 1);
    chk("ms_rel_ir", bus.o_ir, 32'h6666_6666);

    // saturation
    bus.freeze = 1'b1;
    bus.i_ir = 32'h7777_7777;
    repeat (40000) @(posedge clk);
    #1;
    chk("sat_mid", 32'(bus.o_stall_cnt), cnt(40000));
    repeat (25540) @(posedge clk);
    #1;
    chk("sat_cnt", 32'(bus.o_stall_cnt), cnt(32'hFFFF));
    chk("sat_ir", bus.o_ir, 32'h6666_6666);
    chk("sat_held", 32'(bus.o_held), 1);
    bus.freeze = 1'b0;
    step();
    chk("sat_rel_ir", bus.o_ir, 32'h7777_7777);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
